ahb_sram_slave: RTL and testbench

- AHB-Lite single-port responder fronting a synchronous single-port SRAM (1-cycle read latency).
- Serves the load/store and fetch masters through the AHB bus fabric.
- Decodes transfers, generates byte enables, inserts wait states, and returns OKAY/ERROR responses.
- All SRAM accesses happen in the AHB data phase, so pipelined back-to-back transfers never conflict on the SRAM port.

---
 rtl/ahb_sram_slave_pkg.sv | 28 ++
 rtl/ahb_sram_slave_strobe.sv | 34 +++
 rtl/ahb_sram_slave.sv | 117 +++++++++++
 tb/tb_ahb_sram_slave.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared AHB bus widths, transfer codes and slave state encodings
//
// Bus-width macros are shared with the master interfaces; the package carries
// the HTRANS/HSIZE/HRESP codes and the slave FSM state constants.
`ifndef HADDR_BUS
`define HADDR_BUS 31:0
`endif
`ifndef HDATA_BUS
`define HDATA_BUS 31:0
`endif

package ahb_sram_slave_pkg;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;
endpackage

// File: rtl/ahb_sram_slave_strobe.sv
// rtl/ahb_sram_slave_strobe.sv - little-endian byte-lane enables and alignment check
//
// Ports:
//   hsize - AHB transfer size
//   addr  - low two bits of the byte address
//   be    - byte enables, bit i = byte lane i
//   err   - unsupported size or misaligned transfer
module ahb_byte_strobe
  import ahb_sram_slave_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr,
  output logic [3:0] be,
  output logic       err
);

  always_comb begin
    be  = 4'b0000;
    err = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: begin
        be  = addr[1] ? 4'b1100 : 4'b0011;
        err = addr[0];
      end
      HSIZE_WORD: begin
        be  = 4'b1111;
        err = (addr != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite responder fronting a 1-cycle-latency single-port SRAM
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   slv_h*_i              - AHB-Lite address/data phase inputs (hburst/hprot ignored)
//   slv_hreadyout_o       - slave ready, slv_hresp_o - OKAY/ERROR, slv_hrdata_o - read data
//   ram_ce/we/be/addr/wdata_o - SRAM request, ram_rdata_i - SRAM data one cycle after a read
//
// Every SRAM access is issued from the data phase, so an address phase that
// overlaps a previous data phase never competes for the SRAM port.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int RAM_AW      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                slv_hsel_i,
  input  logic [1:0]          slv_htrans_i,
  input  logic [`HADDR_BUS]   slv_haddr_i,
  input  logic                slv_hwrite_i,
  input  logic [2:0]          slv_hsize_i,
  input  logic [2:0]          slv_hburst_i,
  input  logic [3:0]          slv_hprot_i,
  input  logic [`HDATA_BUS]   slv_hwdata_i,
  input  logic                slv_hready_i,
  output logic                slv_hreadyout_o,
  output logic                slv_hresp_o,
  output logic [`HDATA_BUS]   slv_hrdata_o,
  output logic                ram_ce_o,
  output logic                ram_we_o,
  output logic [3:0]          ram_be_o,
  output logic [RAM_AW-1:0]   ram_addr_o,
  output logic [31:0]         ram_wdata_o,
  input  logic [31:0]         ram_rdata_i
);

  // The counter carries one spare bit so the extra read-data cycle still
  // fits when WAIT_STATES is at its maximum of 7.
  localparam logic [3:0] CNT_LAST  = 4'(WAIT_STATES);
  localparam logic [3:0] CNT_RDATA = 4'(WAIT_STATES + 1);

  logic [2:0]        state;
  logic [3:0]        cnt;
  logic [RAM_AW-1:0] addr_l;
  logic [3:0]        be_l;
  logic [3:0]        be_s;
  logic              err_s;
  logic              accept;
  logic              done;
  logic              wr_go;
  logic              rd_go;
  logic              rd_data;

  // Only the word index and byte offset matter; range decode lives in the fabric.
  logic unused_inputs;
  assign unused_inputs = ^{slv_hburst_i, slv_hprot_i, slv_haddr_i[31:RAM_AW+2]};

  ahb_byte_strobe u_strobe (
    .hsize (slv_hsize_i),
    .addr  (slv_haddr_i[1:0]),
    .be    (be_s),
    .err   (err_s)
  );

  assign accept = slv_hsel_i & slv_hready_i &
                  ((slv_htrans_i == HTRANS_NONSEQ) | (slv_htrans_i == HTRANS_SEQ));

  // done marks the last cycle of the current data phase (hreadyout high).
  always_comb begin
    done = 1'b1;
    case (state)
      ST_WR:   done = (cnt == CNT_LAST);
      ST_RD:   done = (cnt == CNT_RDATA);
      ST_ERR1: done = 1'b0;
      default: done = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      addr_l <= '0;
      be_l   <= 4'b0000;
    end else if (done) begin
      if (accept) begin
        cnt    <= 4'd0;
        addr_l <= slv_haddr_i[RAM_AW+1:2];
        be_l   <= be_s;
        state  <= err_s ? ST_ERR1 : (slv_hwrite_i ? ST_WR : ST_RD);
      end else begin
        state <= ST_IDLE;
      end
    end else if (state == ST_ERR1) begin
      state <= ST_ERR2;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  assign wr_go   = (state == ST_WR) && (cnt == CNT_LAST);
  assign rd_go   = (state == ST_RD) && (cnt == CNT_LAST);
  assign rd_data = (state == ST_RD) && (cnt == CNT_RDATA);

  // SRAM request signals are zero outside an access so reset clears them at once.
  assign slv_hreadyout_o = done;
  assign slv_hresp_o     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign slv_hrdata_o    = rd_data ? ram_rdata_i : 32'h0;
  assign ram_ce_o        = wr_go | rd_go;
  assign ram_we_o        = wr_go;
  assign ram_be_o        = wr_go ? be_l : 4'b0000;
  assign ram_addr_o      = (wr_go | rd_go) ? addr_l : '0;
  assign ram_wdata_o     = wr_go ? slv_hwdata_i : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench for ahb_sram_slave at 0 and 3 wait states
module tb_ahb_sram_slave;
  localparam int AW = 12;
  localparam int NQ = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  int          sel;
  logic        mem_init;

  logic          ro [2];
  logic          rs [2];
  logic [31:0]   rd [2];
  logic          ce [2];
  logic          we [2];
  logic [3:0]    be [2];
  logic [AW-1:0] ra [2];
  logic [31:0]   wd [2];
  logic [31:0]   rr [2];

  int total = 0;
  int bad = 0;

  ahb_sram_slave #(.RAM_AW(AW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .slv_hsel_i(hsel && (sel == 0)), .slv_htrans_i(htrans),
    .slv_haddr_i(haddr), .slv_hwrite_i(hwrite), .slv_hsize_i(hsize), .slv_hburst_i(hburst),
    .slv_hprot_i(hprot), .slv_hwdata_i(hwdata), .slv_hready_i(ro[0]),
    .slv_hreadyout_o(ro[0]), .slv_hresp_o(rs[0]), .slv_hrdata_o(rd[0]),
    .ram_ce_o(ce[0]), .ram_we_o(we[0]), .ram_be_o(be[0]), .ram_addr_o(ra[0]),
    .ram_wdata_o(wd[0]), .ram_rdata_i(rr[0]));

  ahb_sram_slave #(.RAM_AW(AW), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .slv_hsel_i(hsel && (sel == 1)), .slv_htrans_i(htrans),
    .slv_haddr_i(haddr), .slv_hwrite_i(hwrite), .slv_hsize_i(hsize), .slv_hburst_i(hburst),
    .slv_hprot_i(hprot), .slv_hwdata_i(hwdata), .slv_hready_i(ro[1]),
    .slv_hreadyout_o(ro[1]), .slv_hresp_o(rs[1]), .slv_hrdata_o(rd[1]),
    .ram_ce_o(ce[1]), .ram_we_o(we[1]), .ram_be_o(be[1]), .ram_addr_o(ra[1]),
    .ram_wdata_o(wd[1]), .ram_rdata_i(rr[1]));

  function automatic logic [31:0] init_word(input int d, input int w);
    return (32'(w) * 32'h9E3779B1) ^ (32'(d) * 32'h0F0F0F0F) ^ 32'h13579BDF;
  endfunction

  // SRAM models, one per instance
  logic [31:0] mem [2][1 << AW];
  for (genvar g = 0; g < 2; g++) begin : g_sram
    always @(posedge clk) begin
      if (mem_init) begin
        for (int w = 0; w < (1 << AW); w++) mem[g][w] <= init_word(g, w);
      end else begin
        if (ce[g] && we[g])
          for (int b = 0; b < 4; b++)
            if (be[g][b]) mem[g][ra[g]][8*b +: 8] <= wd[g][8*b +: 8];
        if (ce[g] && !we[g]) rr[g] <= mem[g][ra[g]];
      end
    end
  end

  // Reference model: byte-addressed memory image per instance
  logic [7:0] ref_mem [2][4 << AW];

  // Transfer queue and observed results
  logic        q_wr    [NQ];
  logic [31:0] q_addr  [NQ];
  logic [2:0]  q_size  [NQ];
  logic [31:0] q_wdata [NQ];
  int          r_cyc   [NQ];
  logic [31:0] r_rdata [NQ];
  logic        r_resp  [NQ];
  logic        r_resp1 [NQ];
  int          r_ce_n  [NQ];
  int          r_ce_cyc[NQ];
  logic        r_ce_we [NQ];
  logic [3:0]  r_ce_be [NQ];
  logic [31:0] r_ce_addr[NQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_q(input int i, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wdat);
    q_wr[i] = wr; q_addr[i] = a; q_size[i] = sz; q_wdata[i] = wdat;
  endtask

  // Drives n transfers fully pipelined; entered and left just after a rising edge.
  task automatic run_seq(input int n);
    int ai, di, cyc, guard;
    logic rdy;
    ai = 0; di = -1; cyc = 0; guard = 0;
    for (int i = 0; i < n; i++) begin
      r_cyc[i] = 0; r_ce_n[i] = 0; r_ce_cyc[i] = 0; r_rdata[i] = 'x; r_resp[i] = 1'bx;
      r_resp1[i] = 1'bx; r_ce_we[i] = 1'bx; r_ce_be[i] = 'x; r_ce_addr[i] = 'x;
    end
    while ((ai < n || di >= 0) && guard < 200) begin
      if (ai < n) begin
        hsel = 1'b1; htrans = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
        haddr = q_addr[ai]; hwrite = q_wr[ai]; hsize = q_size[ai];
        hburst = 3'($urandom); hprot = 4'($urandom);
      end else begin
        hsel = 1'b0; htrans = 2'b00; haddr = $urandom; hwrite = 1'b0; hsize = 3'd0;
      end
      hwdata = (di >= 0 && q_wr[di]) ? q_wdata[di] : 32'h0;
      @(negedge clk);
      rdy = ro[sel];
      if (di >= 0) begin
        cyc++;
        if (cyc == 1) r_resp1[di] = rs[sel];
        if (ce[sel]) begin
          r_ce_n[di]++; r_ce_cyc[di] = cyc; r_ce_we[di] = we[sel];
          r_ce_be[di] = be[sel]; r_ce_addr[di] = 32'(ra[sel]);
        end
        if (rdy) begin
          r_cyc[di] = cyc; r_rdata[di] = rd[sel]; r_resp[di] = rs[sel];
        end
      end
      @(posedge clk); #1;
      guard++;
      if (rdy) begin
        cyc = 0;
        if (ai < n) begin di = ai; ai++; end
        else di = -1;
      end
    end
    hsel = 1'b0; htrans = 2'b00;
    chk("run_seq_timeout", 32'(guard >= 200), 32'd0);
  endtask

  // Checks results against the reference and applies writes to it.
  task automatic verify(input int n, input string tag);
    int ws, a, sz, base, lane;
    logic err;
    logic [3:0] ebe;
    logic [31:0] ew;
    ws = (sel == 1) ? 3 : 0;
    for (int i = 0; i < n; i++) begin
      sz = int'(q_size[i]);
      a = int'(q_addr[i][AW+1:0]);
      err = (sz > 2) || ((a % (1 << sz)) != 0);
      chk($sformatf("%s[%0d].resp", tag, i), 32'(r_resp[i]), 32'(err));
      chk($sformatf("%s[%0d].resp1", tag, i), 32'(r_resp1[i]), 32'(err));
      chk($sformatf("%s[%0d].cycles", tag, i), 32'(r_cyc[i]),
          32'(err ? 2 : (q_wr[i] ? 1 + ws : 2 + ws)));
      chk($sformatf("%s[%0d].ce_count", tag, i), 32'(r_ce_n[i]), err ? 32'd0 : 32'd1);
      if (!err) begin
        chk($sformatf("%s[%0d].ce_cycle", tag, i), 32'(r_ce_cyc[i]), 32'(ws + 1));
        chk($sformatf("%s[%0d].ram_addr", tag, i), r_ce_addr[i], 32'(a / 4));
        chk($sformatf("%s[%0d].ram_we", tag, i), 32'(r_ce_we[i]), 32'(q_wr[i]));
        ebe = 4'b0000;
        if (q_wr[i]) begin
          for (int k = 0; k < (1 << sz); k++) begin
            lane = (a + k) % 4;
            ebe[lane] = 1'b1;
            ref_mem[sel][a + k] = q_wdata[i][8*lane +: 8];
          end
          chk($sformatf("%s[%0d].ram_be", tag, i), 32'(r_ce_be[i]), 32'(ebe));
          chk($sformatf("%s[%0d].wr_hrdata", tag, i), r_rdata[i], 32'h0);
        end else begin
          base = a - (a % 4);
          ew = {ref_mem[sel][base+3], ref_mem[sel][base+2], ref_mem[sel][base+1], ref_mem[sel][base]};
          chk($sformatf("%s[%0d].ram_be", tag, i), 32'(r_ce_be[i]), 32'h0);
          chk($sformatf("%s[%0d].hrdata", tag, i), r_rdata[i], ew);
        end
      end else begin
        chk($sformatf("%s[%0d].err_hrdata", tag, i), r_rdata[i], 32'h0);
      end
    end
  endtask

  task automatic go(input int n, input string tag);
    run_seq(n);
    verify(n, tag);
  endtask

  task automatic chk_reset_outputs(input string tag, input int d);
    chk({tag, ".hreadyout"}, 32'(ro[d]), 32'd1);
    chk({tag, ".hresp"}, 32'(rs[d]), 32'd0);
    chk({tag, ".hrdata"}, rd[d], 32'h0);
    chk({tag, ".ram_ce"}, 32'(ce[d]), 32'd0);
    chk({tag, ".ram_we"}, 32'(we[d]), 32'd0);
    chk({tag, ".ram_be"}, 32'(be[d]), 32'd0);
    chk({tag, ".ram_addr"}, 32'(ra[d]), 32'd0);
    chk({tag, ".ram_wdata"}, wd[d], 32'h0);
  endtask

  // Starts a transfer on dut1, pulls reset in its wait states, checks outputs asynchronously.
  task automatic reset_mid(input logic wr, input logic [31:0] a, input string tag);
    logic [31:0] w;
    sel = 1;
    w = init_word(1, int'(a[AW+1:2]));
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = ~w;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs(tag, 1);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int n;
  logic [31:0] v;
  logic [2:0] sz;

  initial begin
    rst_n = 1'b0; mem_init = 1'b1; sel = 0;
    hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
    hburst = 3'd0; hprot = 4'd0; hwdata = 32'h0;
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < (1 << AW); w++)
        for (int b = 0; b < 4; b++) begin
          v = init_word(d, w);
          ref_mem[d][4*w + b] = v[8*b +: 8];
        end
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    chk_reset_outputs("reset0", 0);
    chk_reset_outputs("reset1", 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // word write then read
    set_q(0, 1'b1, 32'h0000_0010, 3'd2, 32'hDEADBEEF);
    go(1, "wr_word");
    chk("wr_word.be", 32'(r_ce_be[0]), 32'hF);
    chk("wr_word.addr", r_ce_addr[0], 32'd4);
    chk("wr_word.cyc", 32'(r_cyc[0]), 32'd1);
    set_q(0, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
    go(1, "rd_word");
    chk("rd_word.data", r_rdata[0], 32'hDEADBEEF);
    chk("rd_word.cyc", 32'(r_cyc[0]), 32'd2);

    // byte and half writes merge with the preserved byte
    set_q(0, 1'b1, 32'h0000_0013, 3'd0, 32'hAB00_0000);
    go(1, "wr_byte");
    chk("wr_byte.be", 32'(r_ce_be[0]), 32'b1000);
    set_q(0, 1'b1, 32'h0000_0010, 3'd1, 32'h0000_1234);
    go(1, "wr_half");
    chk("wr_half.be", 32'(r_ce_be[0]), 32'b0011);
    set_q(0, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
    go(1, "rd_merge");
    chk("rd_merge.data", r_rdata[0], 32'hABAD1234);

    // back-to-back pipelined write/read/write
    v = $urandom;
    set_q(0, 1'b1, 32'h0000_0020, 3'd2, v);
    set_q(1, 1'b0, 32'h0000_0020, 3'd2, 32'h0);
    set_q(2, 1'b1, 32'h0000_0024, 3'd2, $urandom);
    go(3, "pipe");
    chk("pipe.cyc0", 32'(r_cyc[0]), 32'd1);
    chk("pipe.cyc1", 32'(r_cyc[1]), 32'd2);
    chk("pipe.cyc2", 32'(r_cyc[2]), 32'd1);
    chk("pipe.rdata", r_rdata[1], v);

    // error responses
    set_q(0, 1'b0, 32'h0000_0002, 3'd2, 32'h0);
    set_q(1, 1'b0, 32'h0000_0010, 3'd3, 32'h0);
    go(2, "err");
    chk("err.misalign_cyc", 32'(r_cyc[0]), 32'd2);
    chk("err.misalign_resp", 32'(r_resp[0]), 32'd1);
    chk("err.size3_ce", 32'(r_ce_n[1]), 32'd0);

    // three wait states
    sel = 1;
    v = $urandom;
    set_q(0, 1'b1, 32'h0000_0030, 3'd2, v);
    set_q(1, 1'b0, 32'h0000_0030, 3'd2, 32'h0);
    go(2, "ws3");
    chk("ws3.wr_cyc", 32'(r_cyc[0]), 32'd4);
    chk("ws3.rd_cyc", 32'(r_cyc[1]), 32'd5);
    chk("ws3.rd_ce_cycle", 32'(r_ce_cyc[1]), 32'd4);
    chk("ws3.rd_data", r_rdata[1], v);

    // reset in the middle of read and write wait states
    reset_mid(1'b1, 32'h0000_0040, "rst_wr");
    reset_mid(1'b0, 32'h0000_0044, "rst_rd");
    set_q(0, 1'b0, 32'h0000_0040, 3'd2, 32'h0);
    set_q(1, 1'b0, 32'h0000_0044, 3'd2, 32'h0);
    go(2, "post_rst");
    chk("post_rst.old", r_rdata[0], init_word(1, 16));

    // randomized pipelined batches
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        v = {$urandom} & 32'hFFFF_00FC;
        if ($urandom_range(0, 4) == 0) v[1:0] = 2'($urandom);
        else if (sz == 3'd0) v[1:0] = 2'($urandom);
        else if (sz == 3'd1) v[1] = 1'($urandom);
        set_q(i, 1'($urandom), v, sz, $urandom);
      end
      go(n, $sformatf("rand%0d", it));
    end

    @(negedge clk);
    chk("idle.hrdata0", rd[0], 32'h0);
    chk("idle.ce1", 32'(ce[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
